phy_tx_payload_serializer: RTL and testbench
============================================

Name: phy_tx_payload_serializer

Overview:
Transmit-side counterpart of the PHY RX payload nibble assembler. It accepts payload bytes from the protocol layer over a valid/ready handshake and splits each byte into 4-bit nibbles, low nibble first, for the 4b5b encoder. It computes the USB PD CRC-32 over the payload, appends it as 8 nibbles, then pulses EOP. It sits between the protocol layer and the PHY TX encoder, and runs while the TX control state machine is in its transfer state.

Parameters:
MAX_BYTES, 30, maximum payload bytes per packet (header plus data).
UNDERRUN_CYC, 16, cycles a mid-packet byte may be late before an underrun is flagged.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
pl2phy_tx_payload_start  in  1  pulse; begins a packet (honoured in IDLE only)
pl2phy_tx_payload  in  8  payload byte
pl2phy_tx_payload_en  in  1  byte valid
pl2phy_tx_payload_last  in  1  qualifies the byte as the final payload byte
phy2pl_tx_payload_rdy  out  1  byte ready; a transfer occurs when en and rdy are both high
phy_control_tx_nibble  out  4  nibble to the encoder
phy_control_tx_nibble_en  out  1  nibble valid; held until accepted
phy_control_tx_nibble_rdy  in  1  encoder accepts the nibble when en and rdy are both high
phy_control_tx_payload_eop  out  1  one-cycle pulse after the final nibble is accepted
phy_control_tx_abort  in  1  abandon the current packet
phy2pl_tx_payload_error  out  1  one-cycle pulse on underrun or overflow

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values:
  - State IDLE.
  - All outputs 0.
  - CRC register 0xFFFFFFFF.
  - Byte count 0.
- States: IDLE, LOAD, SEND_LO, SEND_HI, SEND_CRC, EOP.
- IDLE:
  - rdy=0, nibble_en=0.
  - On start: CRC←0xFFFFFFFF, byte_cnt←0, underrun counter←0, go to LOAD.
- LOAD:
  - rdy=1.
  - On byte transfer: latch the byte and its last flag, byte_cnt+1, CRC updated with the byte, go to SEND_LO.
  - nibble_en rises the cycle after the transfer.
  - If byte_cnt≠0, the underrun counter increments each LOAD cycle without a transfer.
  - When the counter reaches UNDERRUN_CYC: error pulse, go to IDLE, no EOP.
  - No timeout applies while waiting for the first byte.
- SEND_LO: nibble=byte[3:0]; on accept go to SEND_HI.
- SEND_HI:
  - nibble=byte[7:4].
  - rdy = nibble_rdy & !last_reg & (byte_cnt<MAX_BYTES). This prefetch gives bubble-free streaming.
  - On accept with a coincident byte transfer: load the byte and go to SEND_LO.
  - On accept without a byte, last_reg=1: go to SEND_CRC.
  - On accept without a byte, last_reg=0 and byte_cnt=MAX_BYTES: overflow error pulse, go to IDLE.
  - On accept without a byte otherwise: go to LOAD, underrun counter←0.
- CRC definition:
  - Reflected CRC-32, polynomial 0xEDB88320 (normal form 0x04C11DB7), init 0xFFFFFFFF.
  - Each byte is processed LSB-first.
  - Transmitted value = ~CRC.
- SEND_CRC:
  - 3-bit nibble index 0..7; nibble = (~CRC)[4i+3:4i], so the least significant nibble goes first.
  - After index 7 is accepted, go to EOP.
- EOP: eop=1 for exactly one cycle, nibble_en=0, then go to IDLE.
- nibble and nibble_en are registered. nibble must not change while en=1 and rdy=0.
- Abort:
  - Abort in any state returns to IDLE next cycle: outputs 0, no EOP, no error.
  - Abort has priority over every other event in the same cycle.
- start outside IDLE is ignored. start and abort together in IDLE: stay in IDLE.
- byte_cnt saturates at MAX_BYTES. Bytes are never accepted beyond MAX_BYTES.
- Latency: byte transfer in LOAD to first nibble_en = 1 cycle. Last CRC nibble accept to EOP pulse = 1 cycle.

Optional Feature:
Macro PHY_TX_PAYLOAD_CRC_EN.
- Defined: CRC-32 logic is present and 8 CRC nibbles are appended as described.
- Undefined: CRC logic and the SEND_CRC state are removed. After the hi nibble of the last byte is accepted, go directly to EOP; the payload is sent unmodified. All other behaviour is unchanged.

Test Plan:
- ASCII "123456789" (0x31..0x39) with last on 0x39, nibble_rdy=1 → 18 data nibbles 1,3,2,3,...,9,3, then CRC nibbles 6,2,9,3,4,F,B,C (CRC 0xCBF43926), then one EOP pulse; no rdy bubbles while bytes are streamed back-to-back.
- Single byte 0xA5 with last, nibble_rdy toggling 1/0 → nibbles 5,A held stable while stalled, then 8 CRC nibbles, then EOP; error stays 0.
- Two bytes, second byte delayed 16 cycles after the first byte's hi nibble is accepted → error pulse on the 16th LOAD cycle, return to IDLE, no EOP, nibble_en=0.
- 30 bytes with last never asserted → rdy stays 0 after byte 30; error pulse when its hi nibble is accepted; no EOP.
- Abort asserted during SEND_CRC index 3 → next cycle IDLE, nibble_en=0, no EOP/error; a following start plus 1 byte produces a correct fresh CRC.
- Assert rst for one cycle mid-SEND_LO → all outputs 0 the next cycle; a start issued mid-packet (no reset) is ignored.

Source files
------------

// File: rtl/phy_tx_payload_serializer.sv
// Payload byte -> low-first nibble serializer for the 4b5b encoder; CRC-32 trailer only when PHY_TX_PAYLOAD_CRC_EN is defined.
// Latency: byte->nibble_en 1 cycle, last nibble->EOP 1 cycle; nibbles hold until accepted, byte rdy prefetches during the hi nibble.
module phy_tx_payload_serializer #(
  parameter int MAX_BYTES    = 30,
  parameter int UNDERRUN_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pl2phy_tx_payload_start,
  input  logic [7:0] pl2phy_tx_payload,
  input  logic       pl2phy_tx_payload_en,
  input  logic       pl2phy_tx_payload_last,
  output logic       phy2pl_tx_payload_rdy,
  output logic [3:0] phy_control_tx_nibble,
  output logic       phy_control_tx_nibble_en,
  input  logic       phy_control_tx_nibble_rdy,
  output logic       phy_control_tx_payload_eop,
  input  logic       phy_control_tx_abort,
  output logic       phy2pl_tx_payload_error
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam int UR_W  = $clog2(UNDERRUN_CYC + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SEND_LO  = 3'd2,
    SEND_HI  = 3'd3,
`ifdef PHY_TX_PAYLOAD_CRC_EN
    SEND_CRC = 3'd4,
`endif
    EOP      = 3'd5
  } state_t;

  state_t           state_q;
  logic [7:0]       byte_q;
  logic             last_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [CNT_W-1:0] byte_cnt_d;
  logic [UR_W-1:0]  ur_cnt_q;
  logic [UR_W-1:0]  ur_cnt_d;
  logic [3:0]       nibble_q;
  logic             nibble_en_q;
  logic             eop_q;
  logic             error_q;
  logic             rdy;
  logic             xfer;
  logic             accept;
  logic             cnt_full;

`ifdef PHY_TX_PAYLOAD_CRC_EN
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] crc_tx;
  logic [2:0]  crc_idx_q;
  logic [2:0]  crc_idx_d;

  // Reflected form: the LSB of the register lines up with the first bit on the wire.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_d     = crc_byte(crc_q, pl2phy_tx_payload);
  assign crc_tx    = ~crc_q;
  assign crc_idx_d = crc_idx_q + 3'd1;
`endif

  assign cnt_full   = (byte_cnt_q == CNT_W'(MAX_BYTES));
  assign byte_cnt_d = cnt_full ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
  assign ur_cnt_d   = ur_cnt_q + UR_W'(1);

  // Masking with rst/abort keeps the protocol layer from believing a byte was taken in a dropped cycle.
  always_comb begin
    rdy = 1'b0;
    case (state_q)
      LOAD:    rdy = 1'b1;
      SEND_HI: rdy = phy_control_tx_nibble_rdy & ~last_q & ~cnt_full;
      default: rdy = 1'b0;
    endcase
    rdy = rdy & ~rst & ~phy_control_tx_abort;
  end

  assign xfer   = pl2phy_tx_payload_en & rdy;
  assign accept = nibble_en_q & phy_control_tx_nibble_rdy;

  always_ff @(posedge clk) begin
    if (rst || phy_control_tx_abort) begin
      state_q     <= IDLE;
      nibble_q    <= 4'h0;
      nibble_en_q <= 1'b0;
      eop_q       <= 1'b0;
      error_q     <= 1'b0;
      if (rst) begin
        byte_q     <= 8'h00;
        last_q     <= 1'b0;
        byte_cnt_q <= '0;
        ur_cnt_q   <= '0;
`ifdef PHY_TX_PAYLOAD_CRC_EN
        crc_q      <= 32'hFFFFFFFF;
        crc_idx_q  <= 3'd0;
`endif
      end
    end else begin
      eop_q   <= 1'b0;
      error_q <= 1'b0;
      if (xfer) begin
        byte_q      <= pl2phy_tx_payload;
        last_q      <= pl2phy_tx_payload_last;
        byte_cnt_q  <= byte_cnt_d;
`ifdef PHY_TX_PAYLOAD_CRC_EN
        crc_q       <= crc_d;
`endif
        nibble_q    <= pl2phy_tx_payload[3:0];
        nibble_en_q <= 1'b1;
        state_q     <= SEND_LO;
      end else begin
        case (state_q)
          IDLE: begin
            if (pl2phy_tx_payload_start) begin
`ifdef PHY_TX_PAYLOAD_CRC_EN
              crc_q      <= 32'hFFFFFFFF;
`endif
              byte_cnt_q <= '0;
              ur_cnt_q   <= '0;
              state_q    <= LOAD;
            end
          end
          LOAD: begin
            // The first byte may take as long as it likes; only mid-packet gaps count.
            if (byte_cnt_q != '0) begin
              if (ur_cnt_d == UR_W'(UNDERRUN_CYC)) begin
                error_q <= 1'b1;
                state_q <= IDLE;
              end else begin
                ur_cnt_q <= ur_cnt_d;
              end
            end
          end
          SEND_LO: begin
            if (accept) begin
              nibble_q <= byte_q[7:4];
              state_q  <= SEND_HI;
            end
          end
          SEND_HI: begin
            if (accept) begin
              if (last_q) begin
`ifdef PHY_TX_PAYLOAD_CRC_EN
                crc_idx_q <= 3'd0;
                nibble_q  <= crc_tx[3:0];
                state_q   <= SEND_CRC;
`else
                nibble_q    <= 4'h0;
                nibble_en_q <= 1'b0;
                eop_q       <= 1'b1;
                state_q     <= EOP;
`endif
              end else if (cnt_full) begin
                nibble_q    <= 4'h0;
                nibble_en_q <= 1'b0;
                error_q     <= 1'b1;
                state_q     <= IDLE;
              end else begin
                nibble_q    <= 4'h0;
                nibble_en_q <= 1'b0;
                ur_cnt_q    <= '0;
                state_q     <= LOAD;
              end
            end
          end
`ifdef PHY_TX_PAYLOAD_CRC_EN
          SEND_CRC: begin
            if (accept) begin
              if (crc_idx_q == 3'd7) begin
                nibble_q    <= 4'h0;
                nibble_en_q <= 1'b0;
                eop_q       <= 1'b1;
                state_q     <= EOP;
              end else begin
                crc_idx_q <= crc_idx_d;
                nibble_q  <= crc_tx[{crc_idx_d, 2'b00} +: 4];
              end
            end
          end
`endif
          EOP: begin
            state_q <= IDLE;
          end
          default: begin
            nibble_en_q <= 1'b0;
            state_q     <= IDLE;
          end
        endcase
      end
    end
  end

  assign phy2pl_tx_payload_rdy      = rdy;
  assign phy_control_tx_nibble      = nibble_q;
  assign phy_control_tx_nibble_en   = nibble_en_q;
  assign phy_control_tx_payload_eop = eop_q;
  assign phy2pl_tx_payload_error    = error_q;

endmodule

// File: tb/tb_phy_tx_payload_serializer.sv
// Directed bench for phy_tx_payload_serializer; CRC expectations apply only when PHY_TX_PAYLOAD_CRC_EN is defined.
module tb_phy_tx_payload_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] payload = 8'h00;
  logic       en = 1'b0;
  logic       last = 1'b0;
  logic       rdy;
  logic [3:0] nib;
  logic       nib_en;
  logic       nib_rdy = 1'b0;
  logic       eop;
  logic       abort = 1'b0;
  logic       err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int bi = 0;
  int first_en = -1;
  bit give_last = 1'b0;
  bit hold_en = 1'b0;
  bit chk_hold = 1'b0;
  bit held_vld = 1'b0;
  logic [3:0] held_nib = 4'h0;

  logic [7:0] stim[$];
  logic [3:0] got[$];
  logic [3:0] exp_q[$];
  int xfer_cycs[$];
  int acc_cycs[$];
  int eop_cycs[$];
  int err_cycs[$];

`ifdef PHY_TX_PAYLOAD_CRC_EN
  localparam int ABORT_AT = 5;
`else
  localparam int ABORT_AT = 1;
`endif

  phy_tx_payload_serializer dut (
    .clk                        (clk),
    .rst                        (rst),
    .pl2phy_tx_payload_start    (start),
    .pl2phy_tx_payload          (payload),
    .pl2phy_tx_payload_en       (en),
    .pl2phy_tx_payload_last     (last),
    .phy2pl_tx_payload_rdy      (rdy),
    .phy_control_tx_nibble      (nib),
    .phy_control_tx_nibble_en   (nib_en),
    .phy_control_tx_nibble_rdy  (nib_rdy),
    .phy_control_tx_payload_eop (eop),
    .phy_control_tx_abort       (abort),
    .phy2pl_tx_payload_error    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later, well before the next rising edge.
  task automatic step(input bit nr, input bit st = 1'b0, input bit ab = 1'b0, input bit rs = 1'b0);
    @(negedge clk);
    cyc++;
    rst     = rs;
    start   = st;
    abort   = ab;
    nib_rdy = nr;
    if (!hold_en && bi < stim.size()) begin
      en      = 1'b1;
      payload = stim[bi];
      last    = give_last && (bi == stim.size() - 1);
    end else begin
      en      = 1'b0;
      payload = 8'h00;
      last    = 1'b0;
    end
    #1;
    if (nib_en && first_en < 0) first_en = cyc;
    if (nib_en && nr) begin
      got.push_back(nib);
      acc_cycs.push_back(cyc);
    end
    if (eop) eop_cycs.push_back(cyc);
    if (err) err_cycs.push_back(cyc);
    if (en && rdy) begin
      xfer_cycs.push_back(cyc);
      bi++;
    end
    if (chk_hold && held_vld && nib_en) check("stall_hold", {28'h0, nib}, {28'h0, held_nib});
    held_vld = nib_en && !nr;
    held_nib = nib;
  endtask

  task automatic clear_log();
    stim.delete();
    got.delete();
    exp_q.delete();
    xfer_cycs.delete();
    acc_cycs.delete();
    eop_cycs.delete();
    err_cycs.delete();
    bi = 0;
    first_en = -1;
    held_vld = 1'b0;
    hold_en = 1'b0;
  endtask

  task automatic exp_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(stim[i][3:0]);
      exp_q.push_back(stim[i][7:4]);
    end
  endtask

`ifdef PHY_TX_PAYLOAD_CRC_EN
  // Normal-form (MSB-first, 0x04C11DB7) shift fed with wire-order bits, reflected at the end.
  task automatic exp_crc(input int n);
    logic [31:0] c;
    logic [31:0] r;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ stim[i][b];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    r = ~r;
    for (int j = 0; j < 8; j++) exp_q.push_back(r[4*j +: 4]);
  endtask
`endif

  task automatic check_nibbles(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check(tag, {28'h0, got[i]}, {28'h0, exp_q[i]});
  endtask

  task automatic run_until_end(input bit toggle);
    for (int k = 0; k < 400; k++) begin
      step(toggle ? (cyc % 2 == 0) : 1'b1);
      if (eop_cycs.size() != 0 || err_cycs.size() != 0) break;
    end
    for (int k = 0; k < 3; k++) step(1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] check_val;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0);
    check("rst_nib", {28'h0, nib}, 32'h0);
    check("rst_nib_en", {31'h0, nib_en}, 32'h0);
    check("rst_eop", {31'h0, eop}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdy", {31'h0, rdy}, 32'h0);

    // "123456789" streamed with the encoder always ready
    clear_log();
    for (int i = 0; i < 9; i++) stim.push_back(8'h31 + 8'(i));
    give_last = 1'b1;
    step(1'b1, 1'b1);
    run_until_end(1'b0);
    exp_bytes(9);
`ifdef PHY_TX_PAYLOAD_CRC_EN
    check_val = 32'hCBF43926;
    for (int j = 0; j < 8; j++) exp_q.push_back(check_val[4*j +: 4]);
`endif
    check_nibbles("t1_nib");
    check("t1_xfers", xfer_cycs.size(), 9);
    if (xfer_cycs.size() == 9) check("t1_no_bubble", xfer_cycs[8] - xfer_cycs[0], 16);
    if (xfer_cycs.size() > 0) check("t1_first_lat", first_en - xfer_cycs[0], 1);
    check("t1_eop_cnt", eop_cycs.size(), 1);
    if (eop_cycs.size() > 0 && acc_cycs.size() > 0) check("t1_eop_lat", eop_cycs[0] - acc_cycs[$], 1);
    check("t1_err_cnt", err_cycs.size(), 0);
    check("t1_idle_en", {31'h0, nib_en}, 32'h0);
    check("t1_idle_rdy", {31'h0, rdy}, 32'h0);

    // Single byte 0xA5 with the encoder stalling every other cycle
    clear_log();
    stim.push_back(8'hA5);
    give_last = 1'b1;
    chk_hold = 1'b1;
    step(1'b1, 1'b1);
    run_until_end(1'b1);
    chk_hold = 1'b0;
    exp_bytes(1);
`ifdef PHY_TX_PAYLOAD_CRC_EN
    exp_crc(1);
`endif
    check_nibbles("t2_nib");
    check("t2_eop_cnt", eop_cycs.size(), 1);
    check("t2_err_cnt", err_cycs.size(), 0);

    // Second byte arrives too late: underrun
    clear_log();
    stim.push_back(8'h11);
    stim.push_back(8'h22);
    give_last = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1);
    check("t3_first_xfer", bi, 1);
    hold_en = 1'b1;
    step(1'b1);
    step(1'b1);
    check("t3_hi_nib", {28'h0, nib}, 32'h1);
    check("t3_hi_rdy", {31'h0, rdy}, 32'h1);
    for (int k = 0; k < 16; k++) begin
      step(1'b1);
      check("t3_wait_rdy", {31'h0, rdy}, 32'h1);
      check("t3_wait_err", {31'h0, err}, 32'h0);
    end
    hold_en = 1'b0;
    step(1'b1);
    check("t3_err", {31'h0, err}, 32'h1);
    check("t3_rdy", {31'h0, rdy}, 32'h0);
    check("t3_nib_en", {31'h0, nib_en}, 32'h0);
    step(1'b1);
    check("t3_err_pulse", {31'h0, err}, 32'h0);
    step(1'b1);
    check("t3_eop_cnt", eop_cycs.size(), 0);
    check("t3_bytes", bi, 1);

    // 30 bytes without last: overflow
    clear_log();
    for (int i = 0; i < 31; i++) stim.push_back(8'(i * 7 + 3));
    give_last = 1'b0;
    step(1'b1, 1'b1);
    run_until_end(1'b0);
    exp_bytes(30);
    check_nibbles("t4_nib");
    check("t4_bytes", bi, 30);
    check("t4_err_cnt", err_cycs.size(), 1);
    if (err_cycs.size() > 0 && acc_cycs.size() > 0) check("t4_err_lat", err_cycs[0] - acc_cycs[$], 1);
    check("t4_eop_cnt", eop_cycs.size(), 0);
    check("t4_nib_en", {31'h0, nib_en}, 32'h0);

    // Abort mid-packet, then a fresh single-byte packet
    clear_log();
    stim.push_back(8'h5A);
    give_last = 1'b1;
    step(1'b1, 1'b1);
    for (int k = 0; k < 50 && got.size() < ABORT_AT; k++) step(1'b1);
    check("t5_pre_abort_en", {31'h0, nib_en}, 32'h1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1);
    check("t5_nib_en", {31'h0, nib_en}, 32'h0);
    check("t5_nib", {28'h0, nib}, 32'h0);
    check("t5_rdy", {31'h0, rdy}, 32'h0);
    step(1'b1);
    step(1'b1);
    check("t5_eop_cnt", eop_cycs.size(), 0);
    check("t5_err_cnt", err_cycs.size(), 0);
    clear_log();
    stim.push_back(8'h00);
    give_last = 1'b1;
    step(1'b1, 1'b1);
    run_until_end(1'b0);
    exp_bytes(1);
`ifdef PHY_TX_PAYLOAD_CRC_EN
    exp_crc(1);
`endif
    check_nibbles("t5_fresh");
    check("t5_fresh_eop", eop_cycs.size(), 1);

    // Reset in SEND_LO, then a start during SEND_HI is ignored
    clear_log();
    stim.push_back(8'h3C);
    give_last = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1);
    check("t6_xfer", bi, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1);
    check("t6_nib", {28'h0, nib}, 32'h0);
    check("t6_nib_en", {31'h0, nib_en}, 32'h0);
    check("t6_eop", {31'h0, eop}, 32'h0);
    check("t6_err", {31'h0, err}, 32'h0);
    check("t6_rdy", {31'h0, rdy}, 32'h0);
    clear_log();
    stim.push_back(8'h12);
    stim.push_back(8'h34);
    give_last = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0, 1'b1);
    run_until_end(1'b0);
    exp_bytes(2);
`ifdef PHY_TX_PAYLOAD_CRC_EN
    exp_crc(2);
`endif
    check_nibbles("t6_nib");
    check("t6_eop_cnt", eop_cycs.size(), 1);
    check("t6_err_cnt", err_cycs.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
